// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module : hazard_pkg
// Brief  : Shared types and default constants for the hazard controller.
// Rev    : 1.0
// ============================================================================
package hazard_pkg;

    localparam int unsigned DEF_AW     = 5;
    localparam int unsigned DEF_MD_LAT = 4;
    localparam int unsigned DEF_CNT_W  = 16;
    localparam int unsigned MD_CNT_W   = 4;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_MD_BUSY = 1'b1
    } md_state_e;

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : hazard_ctrl_if
// Brief  : Pipeline-to-hazard-controller signal bundle.
// Rev    : 1.0
// ============================================================================
interface hazard_ctrl_if
    import hazard_pkg::*;
#(
    parameter int unsigned AW    = DEF_AW,
    parameter int unsigned CNT_W = DEF_CNT_W
) ();

    logic [AW-1:0]    rs_id;
    logic [AW-1:0]    rt_id;
    logic             rs_used_id;
    logic             rt_used_id;
    logic             is_branch_id;
    logic             md_id;
    logic             flush_in;
    logic             ex_regwr;
    logic             ex_memrd;
    logic [AW-1:0]    ex_dst;
    logic             mem_memrd;
    logic [AW-1:0]    mem_dst;

    logic             pc_write;
    logic             ifid_write;
    logic             idex_bubble;
    logic             stall;
    logic             md_busy;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output rs_id, rt_id, rs_used_id, rt_used_id, is_branch_id, md_id,
               flush_in, ex_regwr, ex_memrd, ex_dst, mem_memrd, mem_dst,
        input  pc_write, ifid_write, idex_bubble, stall, md_busy, stall_count
    );

    modport slave (
        input  rs_id, rt_id, rs_used_id, rt_used_id, is_branch_id, md_id,
               flush_in, ex_regwr, ex_memrd, ex_dst, mem_memrd, mem_dst,
        output pc_write, ifid_write, idex_bubble, stall, md_busy, stall_count
    );

endinterface
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module : sat_counter
// Brief  : Up-counter that sticks at all-ones instead of wrapping.
// Rev    : 1.0
// ============================================================================
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         inc,
    output logic      [W-1:0] count
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module : hazard_ctrl
// Brief  : ID-stage stall/bubble control for load-use, branch and mul/div hazards.
// Rev    : 1.0
// ============================================================================
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned AW     = DEF_AW,
    parameter int unsigned MD_LAT = DEF_MD_LAT,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  wire logic   clk,
    input  wire logic   rst,
    hazard_ctrl_if.slave hz
);

    md_state_e             state_q;
    logic [MD_CNT_W-1:0]   md_cnt_q;
    logic                  md_busy_q;

    logic rs_ex, rt_ex, rs_mem, rt_mem;
    logic lw_h, br_ex_h, br_mem_h, data_hz;
    logic stall_c, pc_write_c, ifid_write_c, idex_bubble_c, md_issue_c;

    // Register 0 is hard-wired, so it can never carry a dependency.
    function automatic logic src_match(input logic [AW-1:0] d,
                                       input logic [AW-1:0] s,
                                       input logic          u);
        return u && (s != '0) && (s == d);
    endfunction

    assign rs_ex    = src_match(hz.ex_dst,  hz.rs_id, hz.rs_used_id);
    assign rt_ex    = src_match(hz.ex_dst,  hz.rt_id, hz.rt_used_id);
    assign rs_mem   = src_match(hz.mem_dst, hz.rs_id, hz.rs_used_id);
    assign rt_mem   = src_match(hz.mem_dst, hz.rt_id, hz.rt_used_id);

    assign lw_h     = hz.ex_memrd && (rs_ex || rt_ex);
    assign br_ex_h  = hz.is_branch_id && hz.ex_regwr && (rs_ex || rt_ex);
    assign br_mem_h = hz.is_branch_id && hz.mem_memrd && (rs_mem || rt_mem);
    assign data_hz  = lw_h || br_ex_h || br_mem_h;

    always_comb begin
        stall_c       = 1'b0;
        pc_write_c    = 1'b1;
        ifid_write_c  = 1'b1;
        idex_bubble_c = 1'b0;
        md_issue_c    = 1'b0;
        if (!rst) begin
            pc_write_c    = 1'b0;
            ifid_write_c  = 1'b0;
            idex_bubble_c = 1'b1;
        end else if (state_q == ST_MD_BUSY) begin
            stall_c       = 1'b1;
            pc_write_c    = 1'b0;
            ifid_write_c  = 1'b0;
            idex_bubble_c = 1'b1;
        end else if (hz.flush_in) begin
            idex_bubble_c = 1'b1;
        end else if (data_hz) begin
            stall_c       = 1'b1;
            pc_write_c    = 1'b0;
            ifid_write_c  = 1'b0;
            idex_bubble_c = 1'b1;
        end else begin
            md_issue_c    = hz.md_id;
        end
    end

    // md_cnt counts remaining busy cycles after the issue cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            md_cnt_q  <= '0;
            md_busy_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (md_issue_c) begin
                        state_q   <= ST_MD_BUSY;
                        md_cnt_q  <= MD_CNT_W'(MD_LAT - 2);
                        md_busy_q <= 1'b1;
                    end
                end
                ST_MD_BUSY: begin
                    if (md_cnt_q == '0) begin
                        state_q   <= ST_IDLE;
                        md_busy_q <= 1'b0;
                    end else begin
                        md_cnt_q  <= md_cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    md_cnt_q  <= '0;
                    md_busy_q <= 1'b0;
                end
            endcase
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_c),
        .count (hz.stall_count)
    );

    assign hz.stall       = stall_c;
    assign hz.pc_write    = pc_write_c;
    assign hz.ifid_write  = ifid_write_c;
    assign hz.idex_bubble = idex_bubble_c;
    assign hz.md_busy     = md_busy_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_hazard_ctrl
// Brief  : Directed vectors feed an expectation queue; a negedge monitor checks.
// Rev    : 1.0
// ============================================================================
module tb_hazard_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.AW(5), .CNT_W(4)) hif ();

    hazard_ctrl #(
        .AW     (5),
        .MD_LAT (4),
        .CNT_W  (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hif)
    );

    typedef struct {
        string      nm;
        logic       stall, pc, ifid, bub, busy, chk;
        logic [3:0] cnt;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic cmp(input string nm, input string f, input logic [3:0] act, input logic [3:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s.%s actual=%0h expected=%0h", nm, f, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            cur = q.pop_front();
            cmp(cur.nm, "stall",       {3'b0, hif.stall},       {3'b0, cur.stall});
            cmp(cur.nm, "pc_write",    {3'b0, hif.pc_write},    {3'b0, cur.pc});
            cmp(cur.nm, "ifid_write",  {3'b0, hif.ifid_write},  {3'b0, cur.ifid});
            cmp(cur.nm, "idex_bubble", {3'b0, hif.idex_bubble}, {3'b0, cur.bub});
            cmp(cur.nm, "md_busy",     {3'b0, hif.md_busy},     {3'b0, cur.busy});
            if (cur.chk) cmp(cur.nm, "stall_count", hif.stall_count, cur.cnt);
        end
    end

    task automatic clr();
        hif.rs_id = '0;  hif.rt_id = '0;  hif.rs_used_id = 0; hif.rt_used_id = 0;
        hif.is_branch_id = 0; hif.md_id = 0; hif.flush_in = 0;
        hif.ex_regwr = 0; hif.ex_memrd = 0; hif.ex_dst = '0;
        hif.mem_memrd = 0; hif.mem_dst = '0;
    endtask

    // Push the expectation for the current cycle, then advance to the next one.
    task automatic ex(input string nm, input logic s, input logic p, input logic i,
                      input logic b, input logic y, input logic c, input logic [3:0] n);
        exp_t e;
        e.nm = nm; e.stall = s; e.pc = p; e.ifid = i; e.bub = b; e.busy = y;
        e.chk = c; e.cnt = n;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic set_lw3();
        hif.ex_memrd = 1; hif.ex_dst = 5'd3; hif.rt_id = 5'd3; hif.rt_used_id = 1;
    endtask

    task automatic do_reset();
        clr(); rst = 0;
        ex("rst_hold",    0, 0, 0, 1, 0, 1, 4'd0);
        rst = 1;
        ex("rst_release", 0, 1, 1, 0, 0, 1, 4'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        clr();
        @(posedge clk);
        #1;
        // Reset forces outputs even with a load-use hazard presented.
        set_lw3();
        ex("reset_forced", 0, 0, 0, 1, 0, 1, 4'd0);
        clr(); rst = 1;
        ex("idle",         0, 1, 1, 0, 0, 1, 4'd0);

        set_lw3();
        ex("lw_rt",        1, 0, 0, 1, 0, 1, 4'd0);
        clr(); hif.rt_id = 5'd3; hif.rt_used_id = 1; hif.mem_memrd = 1; hif.mem_dst = 5'd3;
        ex("lw_resolved",  0, 1, 1, 0, 0, 1, 4'd1);

        do_reset();
        clr(); hif.is_branch_id = 1; hif.rs_id = 5'd5; hif.rs_used_id = 1;
        hif.ex_memrd = 1; hif.ex_regwr = 1; hif.ex_dst = 5'd5;
        ex("lw_br_c1",     1, 0, 0, 1, 0, 1, 4'd0);
        hif.ex_memrd = 0; hif.ex_regwr = 0; hif.ex_dst = '0;
        hif.mem_memrd = 1; hif.mem_dst = 5'd5;
        ex("lw_br_c2",     1, 0, 0, 1, 0, 1, 4'd1);
        hif.mem_memrd = 0; hif.mem_dst = '0;
        ex("lw_br_done",   0, 1, 1, 0, 0, 1, 4'd2);
        hif.ex_regwr = 1; hif.ex_dst = 5'd5;
        ex("alu_br_c1",    1, 0, 0, 1, 0, 1, 4'd2);
        hif.ex_regwr = 0; hif.ex_dst = '0; hif.mem_dst = 5'd5;
        ex("alu_br_done",  0, 1, 1, 0, 0, 1, 4'd3);

        clr(); hif.is_branch_id = 1; hif.rs_id = '0; hif.rs_used_id = 1;
        hif.ex_regwr = 1; hif.ex_dst = '0;
        ex("r0_no_hz",     0, 1, 1, 0, 0, 0, 4'd0);
        clr(); hif.rs_id = '0; hif.rs_used_id = 1; hif.rt_id = 5'd7; hif.rt_used_id = 1;
        hif.ex_memrd = 1; hif.ex_dst = 5'd7;
        ex("rs0_rt7",      1, 0, 0, 1, 0, 0, 4'd0);
        hif.rt_used_id = 0;
        ex("rt_unused",    0, 1, 1, 0, 0, 0, 4'd0);
        clr(); hif.rs_id = 5'd7; hif.rs_used_id = 1; hif.ex_memrd = 1; hif.ex_dst = 5'd7;
        ex("rs7_rt0",      1, 0, 0, 1, 0, 0, 4'd0);
        hif.flush_in = 1;
        ex("flush_wins",   0, 1, 1, 1, 0, 0, 4'd0);
        clr(); hif.rs_id = 5'd4; hif.rs_used_id = 1; hif.mem_memrd = 1; hif.mem_dst = 5'd4;
        ex("mem_lw_alu",   0, 1, 1, 0, 0, 0, 4'd0);

        do_reset();
        clr(); hif.md_id = 1;
        ex("md_issue",     0, 1, 1, 0, 0, 1, 4'd0);
        clr();
        ex("md_busy1",     1, 0, 0, 1, 1, 1, 4'd0);
        hif.flush_in = 1;
        ex("md_busy2_fl",  1, 0, 0, 1, 1, 1, 4'd1);
        clr(); set_lw3();
        ex("md_busy3",     1, 0, 0, 1, 1, 1, 4'd2);
        clr();
        ex("md_done",      0, 1, 1, 0, 0, 1, 4'd3);
        set_lw3(); hif.md_id = 1;
        ex("md_hz_hold",   1, 0, 0, 1, 0, 1, 4'd3);
        clr();
        ex("md_no_issue",  0, 1, 1, 0, 0, 1, 4'd4);
        hif.md_id = 1; hif.flush_in = 1;
        ex("md_flushed",   0, 1, 1, 1, 0, 1, 4'd4);
        clr();
        ex("md_fl_idle",   0, 1, 1, 0, 0, 1, 4'd4);

        do_reset();
        for (int i = 0; i < 19; i++) begin
            clr(); set_lw3();
            ex($sformatf("sat_%0d", i), 1, 0, 0, 1, 0, 1, (i > 15) ? 4'd15 : 4'(i));
        end
        clr();
        ex("sat_hold1",    0, 1, 1, 0, 0, 1, 4'd15);
        ex("sat_hold2",    0, 1, 1, 0, 0, 1, 4'd15);

        hif.md_id = 1;
        ex("md2_issue",    0, 1, 1, 0, 0, 1, 4'd15);
        clr();
        ex("md2_busy",     1, 0, 0, 1, 1, 1, 4'd15);
        rst = 0;
        ex("md2_async_rst",0, 0, 0, 1, 0, 1, 4'd0);
        rst = 1;
        ex("md2_after_rst",0, 1, 1, 0, 0, 1, 4'd0);
        ex("md2_idle",     0, 1, 1, 0, 0, 1, 4'd0);

        for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
